// File: rtl/instr_loader_ram.sv
// Writable instruction store for MCPU5. Programs are loaded over a valid/ready port,
// and the CPU reads them through a ROM-compatible combinational port.
module instr_loader_ram #(
    parameter int         DEPTH = 64,
    parameter int         AW    = 6,
    parameter logic [5:0] FILL  = 6'h3F
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          load_end,
    input  logic          data_valid,
    input  logic [5:0]    data_in,
    output logic          ready,
    output logic [AW:0]   word_count,
    output logic          cpu_hold,
    input  logic [7:0]    address,
    output logic [5:0]    instruction
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t      state_q, state_d;
    logic [AW:0] word_count_q, word_count_d;
    logic        mem_we;
    logic [5:0]  mem [DEPTH];

    logic [8:0]  addr_ext;
    logic [8:0]  count_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
        end
    end

    // Program storage is never cleared; stale words are hidden by the word_count read mask.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_count_q[AW-1:0]] <= data_in;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        mem_we       = 1'b0;
        ready        = (state_q == LOAD) && (word_count_q < DEPTH_C);
        cpu_hold     = (state_q != RUN);

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d      = LOAD;
                    word_count_d = '0;
                end else if (load_end) begin
                    state_d      = RUN;
                    word_count_d = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    word_count_d = '0;
                end else begin
                    if (data_valid && ready && rst_n) begin
                        mem_we       = 1'b1;
                        word_count_d = word_count_q + ONE_C;
                    end
                    // A word arriving with load_end is committed before the switch to RUN.
                    if (load_end || (word_count_d == DEPTH_C)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d      = LOAD;
                    word_count_d = '0;
                end
            end
            default: begin
                state_d      = IDLE;
                word_count_d = '0;
            end
        endcase
    end

    always_comb begin
        addr_ext  = {1'b0, address};
        count_ext = 9'(word_count_q);
        if ((state_q == RUN) && (addr_ext < count_ext)) begin
            instruction = mem[address[AW-1:0]];
        end else begin
            instruction = FILL;
        end
    end

    assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_loader_ram.sv
// Directed bench for instr_loader_ram: a vector table for the basic load/read flow,
// plus hand-written sequences for random-valid streaming, full-depth, restart and reset.
module tb_instr_loader_ram;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic       load_end;
    logic       data_valid;
    logic [5:0] data_in;
    logic       ready;
    logic [6:0] word_count;
    logic       cpu_hold;
    logic [7:0] address;
    logic [5:0] instruction;

    int checks = 0;
    int errors = 0;

    instr_loader_ram #(
        .DEPTH(64),
        .AW(6),
        .FILL(6'h3F)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_start(load_start),
        .load_end(load_end),
        .data_valid(data_valid),
        .data_in(data_in),
        .ready(ready),
        .word_count(word_count),
        .cpu_hold(cpu_hold),
        .address(address),
        .instruction(instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ls;
        logic       le;
        logic       dv;
        logic [5:0] din;
        logic [7:0] addr;
        logic       exp_ready;
        logic [6:0] exp_count;
        logic       exp_hold;
        logic [5:0] exp_instr;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ls, input logic le, input logic dv,
                                 input logic [5:0] din, input logic [7:0] addr);
        load_start = ls;
        load_end   = le;
        data_valid = dv;
        data_in    = din;
        address    = addr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string name, input logic [7:0] addr, input logic [5:0] expected);
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, addr);
        checkOutput(name, int'(instruction), int'(expected));
        step();
    endtask

    function automatic logic [5:0] word_a(input int i);
        return 6'((i * 5 + 1) % 63);
    endfunction

    function automatic logic [5:0] word_b(input int i);
        return 6'((i * 3 + 2) % 63);
    endfunction

    initial begin
        int idx;
        int cyc;
        logic dv;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 7'd0, 1'b1, 6'h3F};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 6'h1F, 8'h00, 1'b1, 7'd0, 1'b1, 6'h3F};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 6'h2F, 8'h00, 1'b1, 7'd1, 1'b1, 6'h3F};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 6'h12, 8'h00, 1'b1, 7'd2, 1'b1, 6'h3F};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 6'h28, 8'h00, 1'b1, 7'd3, 1'b1, 6'h3F};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 6'h3B, 8'h00, 1'b1, 7'd4, 1'b1, 6'h3F};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 7'd5, 1'b1, 6'h3F};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 7'd5, 1'b0, 6'h1F};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h01, 1'b0, 7'd5, 1'b0, 6'h2F};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h02, 1'b0, 7'd5, 1'b0, 6'h12};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h03, 1'b0, 7'd5, 1'b0, 6'h28};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h04, 1'b0, 7'd5, 1'b0, 6'h3B};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h05, 1'b0, 7'd5, 1'b0, 6'h3F};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'h80, 1'b0, 7'd5, 1'b0, 6'h3F};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 6'h00, 8'hFF, 1'b0, 7'd5, 1'b0, 6'h3F};

        // Reset for two cycles, then sweep the whole address space.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("reset_ready", int'(ready), 0);
        checkOutput("reset_hold", int'(cpu_hold), 1);
        checkOutput("reset_count", int'(word_count), 0);
        for (int a = 0; a < 256; a++) begin
            readCheck("reset_sweep", 8'(a), 6'h3F);
        end

        // Basic five-word load followed by load_end.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ls, vecs[i].le, vecs[i].dv, vecs[i].din, vecs[i].addr);
            checkOutput($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_count", i), int'(word_count), int'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d_hold", i), int'(cpu_hold), int'(vecs[i].exp_hold));
            checkOutput($sformatf("vec%0d_instr", i), int'(instruction), int'(vecs[i].exp_instr));
            step();
        end

        // 35 words with data_valid toggling randomly.
        applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
        step();
        checkOutput("rand_enter_hold", int'(cpu_hold), 1);
        checkOutput("rand_enter_count", int'(word_count), 0);
        idx = 0;
        cyc = 0;
        while (idx < 35 && cyc < 1000) begin
            dv = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, 1'b0, dv, word_a(idx), 8'h00);
            step();
            if (dv) idx++;
            cyc++;
        end
        if (cyc >= 1000) begin
            errors++;
            $display("[TB] FAIL rand_stream_timeout: got %0d words, expected 35", idx);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 8'h00);
        checkOutput("rand_count_load", int'(word_count), 35);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("rand_hold_run", int'(cpu_hold), 0);
        checkOutput("rand_count_run", int'(word_count), 35);
        for (int i = 0; i < 35; i++) begin
            readCheck($sformatf("rand_read%0d", i), 8'(i), word_a(i));
        end
        readCheck("rand_read35", 8'd35, 6'h3F);

        // Full-depth load with no load_end: auto transition to RUN.
        applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
        step();
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, word_b(i), 8'h00);
            if (i == 0 || i == 63) begin
                checkOutput($sformatf("full_ready%0d", i), int'(ready), 1);
            end
            step();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 6'h15, 8'h00);
        checkOutput("full_ready_drop", int'(ready), 0);
        checkOutput("full_auto_run", int'(cpu_hold), 0);
        checkOutput("full_count", int'(word_count), 64);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("full_count_held", int'(word_count), 64);
        readCheck("full_read0", 8'd0, word_b(0));
        readCheck("full_read63", 8'd63, word_b(63));
        readCheck("full_read64", 8'd64, 6'h3F);

        // load_end together with the third word.
        applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 6'h05, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 6'h06, 8'h00);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 6'h07, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("endword_count", int'(word_count), 3);
        checkOutput("endword_hold", int'(cpu_hold), 0);
        readCheck("endword_read2", 8'd2, 6'h07);
        readCheck("endword_read3", 8'd3, 6'h3F);

        // Restart mid-load: the word presented with load_start is discarded.
        applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
        step();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 6'(6'h20 + i), 8'h00);
            step();
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 6'h11, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("restart_count", int'(word_count), 0);
        checkOutput("restart_ready", int'(ready), 1);
        checkOutput("restart_hold", int'(cpu_hold), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'h0A, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 6'h0B, 8'h00);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("restart_final_count", int'(word_count), 2);
        readCheck("restart_read0", 8'd0, 6'h0A);
        readCheck("restart_read1", 8'd1, 6'h0B);
        readCheck("restart_read2", 8'd2, 6'h3F);

        // Reset during LOAD, then load_end from IDLE gives an empty program.
        applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 6'(6'h30 + i), 8'h00);
            step();
        end
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("midreset_count", int'(word_count), 0);
        checkOutput("midreset_ready", int'(ready), 0);
        checkOutput("midreset_hold", int'(cpu_hold), 1);
        readCheck("midreset_read0", 8'd0, 6'h3F);
        readCheck("midreset_read1", 8'd1, 6'h3F);
        applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        checkOutput("empty_run_hold", int'(cpu_hold), 0);
        checkOutput("empty_run_count", int'(word_count), 0);
        readCheck("empty_run_read0", 8'd0, 6'h3F);
        readCheck("empty_run_read1", 8'd1, 6'h3F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
